// File: rtl/pulse_meas_pkg.sv
// Shared types and defaults for the pulse period meter.
package pulse_meas_pkg;

  localparam int unsigned CNT_W_DEF       = 24;
  localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd1000000;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    TMO
  } meas_state_e;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Result handshake bundle: producer drives valid + data, consumer drives ready.
interface pulse_period_meter_if
  import pulse_meas_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;

  modport master (
    output meas_valid,
    output period,
    output high_time,
    input  meas_ready
  );

  modport slave (
    input  meas_valid,
    input  period,
    input  high_time,
    output meas_ready
  );

endinterface

// File: rtl/pulse_edge_det.sv
// Registers pulse_in once per cycle and flags its rising and falling edges.
module pulse_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic rise,
  output logic fall
);

  logic pulse_d_q;
  logic pulse_d_d;

  always_comb begin
    pulse_d_d = pulse_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_d_q <= 1'b0;
    end else begin
      pulse_d_q <= pulse_d_d;
    end
  end

  assign rise = pulse_in & ~pulse_d_q;
  assign fall = ~pulse_in & pulse_d_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures period and high time of pulse_in between rising edges, with
// valid/ready result handoff, no-edge timeout and sticky overrun flag.
module pulse_period_meter
  import pulse_meas_pkg::*;
#(
  parameter int unsigned      CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(TIMEOUT_CYC_DEF)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pulse_in,
  input  logic                        enable,
  pulse_period_meter_if.master        res_if,
  output logic                        timeout,
  output logic                        overrun,
  output logic [15:0]                 edge_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rise;
  logic fall;

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic             high_open_q, high_open_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      edge_count_q, edge_count_d;
  logic             load;
  logic             restart;

  pulse_edge_det u_edge_det (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .rise     (rise),
    .fall     (fall)
  );

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    high_open_d  = high_open_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q;
    edge_count_d = edge_count_q;
    load         = 1'b0;
    restart      = 1'b0;

    if (state_q != IDLE && enable && rise) begin
      edge_count_d = edge_count_q + 16'd1;
    end

    if (state_q != IDLE && !enable) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      high_open_d  = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          period_cnt_d = '0;
          high_cnt_d   = '0;
          high_open_d  = 1'b0;
          timeout_d    = 1'b0;
          if (enable) state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            state_d = MEASURE;
            restart = 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            restart = 1'b1;
            if (!meas_valid_q || res_if.meas_ready) begin
              load = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else if (period_cnt_q == TIMEOUT_CYC) begin
            state_d   = TMO;
            timeout_d = 1'b1;
          end else begin
            period_cnt_d = period_cnt_q + CNT_ONE;
            // high time stops accumulating at the first fall of the period
            if (high_open_q) begin
              if (fall) high_open_d = 1'b0;
              else      high_cnt_d  = high_cnt_q + CNT_ONE;
            end
          end
        end
        TMO: begin
          if (rise) begin
            state_d   = MEASURE;
            timeout_d = 1'b0;
            restart   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (restart) begin
      period_cnt_d = CNT_ONE;
      high_cnt_d   = CNT_ONE;
      high_open_d  = 1'b1;
    end

    if (load) begin
      period_d    = period_cnt_q;
      high_time_d = high_cnt_q;
    end

    if (load) begin
      meas_valid_d = 1'b1;
    end else if (meas_valid_q && res_if.meas_ready) begin
      meas_valid_d = 1'b0;
    end else begin
      meas_valid_d = meas_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      high_open_q  <= 1'b0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      edge_count_q <= '0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      high_open_q  <= high_open_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
      edge_count_q <= edge_count_d;
    end
  end

  assign res_if.meas_valid = meas_valid_q;
  assign res_if.period     = period_q;
  assign res_if.high_time  = high_time_q;
  assign timeout           = timeout_q;
  assign overrun           = overrun_q;
  assign edge_count        = edge_count_q;

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 Parameter CNT_W, default 24, width of period/high-time counters and results.
REQ-002 Parameter TIMEOUT_CYC, default 24'd1000000, cycles without a rising edge before timeout; SHALL satisfy 2 <= TIMEOUT_CYC < 2**CNT_W.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pulse_in  input  1  square wave from upstream pulse generator, same clock domain.
REQ-006 enable  input  1  measurement enable.
REQ-007 meas_ready  input  1  consumer accepts result.
REQ-008 meas_valid  output  1  result registers hold an unconsumed measurement.
REQ-009 period  output  CNT_W  clk cycles between consecutive detected rising edges.
REQ-010 high_time  output  CNT_W  clk cycles pulse_in was sampled high within that period.
REQ-011 timeout  output  1  no rising edge within TIMEOUT_CYC cycles.
REQ-012 overrun  output  1  sticky; a measurement was dropped.
REQ-013 edge_count  output  16  rising edges detected while enabled.

Function
REQ-014 pulse_d SHALL register pulse_in every cycle regardless of state; rise = pulse_in & ~pulse_d; fall = ~pulse_in & pulse_d.
REQ-015 States SHALL be IDLE, ARM, MEASURE, TMO.
REQ-016 IDLE: counters held at 0; enable=1 -> ARM next cycle; rises ignored.
REQ-017 ARM: on rise -> MEASURE, period_cnt<=1, high_cnt<=1; no result produced.
REQ-018 MEASURE: period_cnt increments each cycle; high_cnt increments each cycle pulse_in=1 until first fall of the period, then holds.
REQ-019 MEASURE on rise: if meas_valid=0 or meas_ready=1, period<=period_cnt, high_time<=high_cnt, meas_valid<=1; else results unchanged and overrun<=1; counters restart at 1; stay MEASURE.
REQ-020 Handshake: meas_valid & meas_ready with no simultaneous load SHALL clear meas_valid next cycle; simultaneous accept and load keeps meas_valid=1, no overrun.
REQ-021 MEASURE with period_cnt == TIMEOUT_CYC and no rise -> TMO, timeout<=1; counters freeze (no wrap).
REQ-022 TMO: on rise -> MEASURE, timeout<=0, counters<=1, no result.
REQ-023 enable=0 in any non-IDLE state -> IDLE next cycle, timeout<=0; pending meas_valid/results retained until handshake.
REQ-024 edge_count SHALL increment on every rise while state != IDLE, wrapping 16'hFFFF -> 0.
REQ-025 Result latency: period/high_time/meas_valid update in the cycle after the rise is sampled.

Reset
REQ-026 rst=1 SHALL force state IDLE, pulse_d=0, all counters 0, meas_valid=0, period=0, high_time=0, timeout=0, overrun=0, edge_count=0; rst has priority over all other inputs.
REQ-027 overrun SHALL clear only on rst.
REQ-028 rst mid-measurement SHALL discard the partial measurement; first result after rst requires ARM then one full period.

Structure
REQ-029 Package pulse_meas_pkg SHALL hold the state enumeration, CNT_W default and TIMEOUT_CYC default.
REQ-030 Sub-module pulse_edge_det (pulse_d register, rise/fall outputs) SHALL be instantiated once.

Verification
REQ-031 Upstream generator toggling every 51 cycles, enable=1, meas_ready=1 -> from second result on, period=102, high_time=51 each period.
REQ-032 meas_ready=0 across two rises -> first result held, overrun=1, meas_valid stays 1; then meas_ready=1 one cycle -> meas_valid=0.
REQ-033 TIMEOUT_CYC=200, pulse_in stuck 0 after a rise -> timeout=1 exactly 200 cycles after the rise; next rise -> timeout=0, no result.
REQ-034 enable dropped mid-period -> IDLE, no new result, edge_count stops; re-enable -> ARM, first result one full period after the next rise.
REQ-035 rst asserted mid-MEASURE with meas_valid=1 -> all outputs 0 next cycle; pulse_in=1 held through reset release produces no false rise.
REQ-036 65537 rises -> edge_count=1.
